// File: rtl/wb_port_arbiter_if.sv
// Bundle between the EX/MEM result producers and the register-file write
// arbiter. The master side is the requester pair, the slave side is the
// arbiter that owns the write port and the flag register.
interface wb_port_arbiter_if;
  // EX result channel
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_result;
  logic [3:0]  ex_nzcv;
  logic        ex_flag_en;
  logic [4:0]  ex_reg_idx_dst;
  // load-return channel
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [4:0]  mem_reg_idx_dst;
  // register-file write port and architectural flags
  logic        reg_w_en;
  logic [4:0]  reg_w_idx;
  logic [15:0] reg_w_data;
  logic [3:0]  nzcv;
  logic        force_ex;

  modport master (
    output ex_valid, ex_result, ex_nzcv, ex_flag_en, ex_reg_idx_dst,
    output mem_valid, mem_data, mem_reg_idx_dst,
    input  ex_ready, mem_ready,
    input  reg_w_en, reg_w_idx, reg_w_data, nzcv, force_ex
  );

  modport slave (
    input  ex_valid, ex_result, ex_nzcv, ex_flag_en, ex_reg_idx_dst,
    input  mem_valid, mem_data, mem_reg_idx_dst,
    output ex_ready, mem_ready,
    output reg_w_en, reg_w_idx, reg_w_data, nzcv, force_ex
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: two producers (EX results, load returns) share a
// single register-file write port. Loads normally win; an EX request that
// has lost STARVE_LIMIT consecutive cycles gets one forced grant.
// STARVE_LIMIT must lie in 1..15 so it fits the 4-bit starvation counter.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic {NORMAL, FORCE_EX} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ex_rdy, mem_rdy;
  logic        ex_xfer, mem_xfer;

  logic        w_en_q;
  logic [4:0]  w_idx_q;
  logic [15:0] w_data_q;
  logic [3:0]  nzcv_q;

  // Grant selection: ready is purely a function of the valids and the
  // registered state, so it also behaves correctly while reset is held.
  always_comb begin
    ex_rdy  = 1'b0;
    mem_rdy = 1'b0;
    if (state_q == FORCE_EX) begin
      ex_rdy  = bus.ex_valid;
      mem_rdy = bus.mem_valid & ~bus.ex_valid;
    end else begin
      mem_rdy = bus.mem_valid;
      ex_rdy  = bus.ex_valid & ~bus.mem_valid;
    end
  end

  assign ex_xfer  = bus.ex_valid  & ex_rdy;
  assign mem_xfer = bus.mem_valid & mem_rdy;

  // Next starvation count and state; the state is a pure decode of the
  // counter so FORCE_EX lasts exactly as long as the counter sits at limit.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = NORMAL;
    if (!bus.ex_valid || ex_xfer) begin
      cnt_d = 4'd0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (cnt_d == LIMIT) begin
      state_d = FORCE_EX;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      state_q <= NORMAL;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Write port register: one write per transfer, index/data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_en_q   <= 1'b0;
      w_idx_q  <= 5'd0;
      w_data_q <= 16'd0;
    end else begin
      w_en_q <= ex_xfer | mem_xfer;
      if (ex_xfer) begin
        w_idx_q  <= bus.ex_reg_idx_dst;
        w_data_q <= bus.ex_result;
      end else if (mem_xfer) begin
        w_idx_q  <= bus.mem_reg_idx_dst;
        w_data_q <= bus.mem_data;
      end
    end
  end

  // Flag register: only an EX transfer that asks for it touches the flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv_q <= 4'd0;
    end else if (ex_xfer && bus.ex_flag_en) begin
      nzcv_q <= bus.ex_nzcv;
    end
  end

  assign bus.ex_ready   = ex_rdy;
  assign bus.mem_ready  = mem_rdy;
  assign bus.reg_w_en   = w_en_q;
  assign bus.reg_w_idx  = w_idx_q;
  assign bus.reg_w_data = w_data_q;
  assign bus.nzcv       = nzcv_q;
  assign bus.force_ex   = (state_q == FORCE_EX);

  // Never two grants in one cycle.
  a_one_grant: assert property (@(posedge clk) disable iff (reset)
    !(ex_xfer && mem_xfer));

  // Counter never runs past the limit.
  a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    cnt_q <= LIMIT);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: requests are queued per channel,
// a behavioural arbiter model predicts grants and pushes expected writes,
// which are popped and compared when the write port fires.
module tb_wb_port_arbiter;

  localparam int LIMIT = 3;

  typedef struct {
    logic [4:0]  idx;
    logic [15:0] data;
    logic [3:0]  nz;
    logic        fe;
  } req_t;

  typedef struct {
    logic [4:0]  idx;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  req_t ex_q[$];
  req_t mem_q[$];
  wr_t  exp_q[$];
  int   m_cnt = 0;
  logic [3:0] m_nzcv = 4'd0;
  logic exp_wen = 1'b0;
  int   run = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic [4:0] idx, input logic [15:0] data,
                              input logic [3:0] nz, input logic fe);
    req_t r;
    r.idx = idx; r.data = data; r.nz = nz; r.fe = fe;
    return r;
  endfunction

  function automatic wr_t mkw(input logic [4:0] idx, input logic [15:0] data);
    wr_t w;
    w.idx = idx; w.data = data;
    return w;
  endfunction

  // Present queue heads, check previous-cycle write and current grants at
  // the falling edge, advance the model, then move past the rising edge.
  task automatic cycle();
    logic ev, mv, frc, er, mr;
    wr_t  w;
    bus.ex_valid = (ex_q.size() != 0);
    if (bus.ex_valid) begin
      bus.ex_reg_idx_dst = ex_q[0].idx;
      bus.ex_result      = ex_q[0].data;
      bus.ex_nzcv        = ex_q[0].nz;
      bus.ex_flag_en     = ex_q[0].fe;
    end else begin
      bus.ex_reg_idx_dst = 5'($urandom);
      bus.ex_result      = 16'($urandom);
      bus.ex_nzcv        = 4'($urandom);
      bus.ex_flag_en     = 1'($urandom);
    end
    bus.mem_valid = (mem_q.size() != 0);
    if (bus.mem_valid) begin
      bus.mem_reg_idx_dst = mem_q[0].idx;
      bus.mem_data        = mem_q[0].data;
    end else begin
      bus.mem_reg_idx_dst = 5'($urandom);
      bus.mem_data        = 16'($urandom);
    end
    @(negedge clk);
    chk("w_en", 32'(bus.reg_w_en), 32'(exp_wen));
    if (exp_wen && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("w_idx", 32'(bus.reg_w_idx), 32'(w.idx));
      chk("w_data", 32'(bus.reg_w_data), 32'(w.data));
    end
    if (bus.reg_w_en) run++; else run = 0;
    if (run > max_run) max_run = run;
    chk("nzcv", 32'(bus.nzcv), 32'(m_nzcv));
    frc = (m_cnt == LIMIT);
    chk("force_ex", 32'(bus.force_ex), 32'(frc));
    ev = bus.ex_valid;
    mv = bus.mem_valid;
    er = frc ? ev : (ev & ~mv);
    mr = frc ? (mv & ~ev) : mv;
    chk("ex_ready", 32'(bus.ex_ready), 32'(er));
    chk("mem_ready", 32'(bus.mem_ready), 32'(mr));
    exp_wen = er | mr;
    if (er) begin
      exp_q.push_back(mkw(ex_q[0].idx, ex_q[0].data));
      if (ex_q[0].fe) m_nzcv = ex_q[0].nz;
      void'(ex_q.pop_front());
    end else if (mr) begin
      exp_q.push_back(mkw(mem_q[0].idx, mem_q[0].data));
      void'(mem_q.pop_front());
    end
    if (!ev || er) m_cnt = 0;
    else if (m_cnt != LIMIT) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((ex_q.size() != 0 || mem_q.size() != 0 || exp_wen) && n < 80) begin
      cycle();
      n++;
    end
    if (n >= 80) chk("drain_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    bus.ex_valid = 1'b0; bus.mem_valid = 1'b0;
    bus.ex_result = '0; bus.ex_nzcv = '0; bus.ex_flag_en = 1'b0;
    bus.ex_reg_idx_dst = '0; bus.mem_data = '0; bus.mem_reg_idx_dst = '0;

    // Reset state, asserted between edges
    #1 reset = 1'b1;
    #2;
    chk("rst_w_en", 32'(bus.reg_w_en), 32'd0);
    chk("rst_w_idx", 32'(bus.reg_w_idx), 32'd0);
    chk("rst_w_data", 32'(bus.reg_w_data), 32'd0);
    chk("rst_nzcv", 32'(bus.nzcv), 32'd0);
    chk("rst_force", 32'(bus.force_ex), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Single EX with flags
    ex_q.push_back(mk(5'd5, 16'h1234, 4'b1001, 1'b1));
    drain();

    // Same index from both channels: MEM first, EX second
    ex_q.push_back(mk(5'd3, 16'hAAAA, 4'b0011, 1'b0));
    mem_q.push_back(mk(5'd3, 16'h5555, 4'b0000, 1'b0));
    drain();

    // MEM never touches nzcv
    ex_q.push_back(mk(5'd1, 16'h0001, 4'b0110, 1'b1));
    drain();
    mem_q.push_back(mk(5'd7, 16'hBEEF, 4'b1111, 1'b1));
    drain();

    // Starvation: MEM streams, EX must be forced in after LIMIT losses
    for (int i = 0; i < 7; i++) mem_q.push_back(mk(5'(10 + i), 16'(16'hC000 + i), 4'd0, 1'b0));
    ex_q.push_back(mk(5'd20, 16'hE0E0, 4'b1100, 1'b1));
    drain();

    // Streaming loads, index 0 included, no bubbles
    max_run = 0; run = 0;
    for (int i = 0; i < 8; i++) mem_q.push_back(mk(5'(i), 16'(16'h7100 + i), 4'd0, 1'b0));
    drain();
    chk("stream_run", 32'(max_run), 32'd8);

    // EX without flag enable leaves nzcv alone
    ex_q.push_back(mk(5'd0, 16'h00FF, 4'b0001, 1'b0));
    drain();

    // Random traffic
    for (int c = 0; c < 80; c++) begin
      if ($urandom_range(0, 2) == 0 && ex_q.size() < 3)
        ex_q.push_back(mk(5'($urandom), 16'($urandom), 4'($urandom), 1'($urandom)));
      if ($urandom_range(0, 1) == 0 && mem_q.size() < 3)
        mem_q.push_back(mk(5'($urandom), 16'($urandom), 4'd0, 1'b0));
      cycle();
    end
    drain();

    // Reset mid-operation: EX granted, reset hits before the capturing edge
    ex_q.push_back(mk(5'd2, 16'h2222, 4'b1111, 1'b1));
    drain();
    bus.ex_valid = 1'b1; bus.ex_reg_idx_dst = 5'd9; bus.ex_result = 16'h0F0F;
    bus.ex_nzcv = 4'b0101; bus.ex_flag_en = 1'b1; bus.mem_valid = 1'b0;
    @(negedge clk);
    chk("mid_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("mid_w_en_pre", 32'(bus.reg_w_en), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_nzcv", 32'(bus.nzcv), 32'd0);
    chk("mid_w_en", 32'(bus.reg_w_en), 32'd0);
    chk("mid_ready_rst", 32'(bus.ex_ready), 32'd1);
    bus.ex_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_w_en_edge", 32'(bus.reg_w_en), 32'd0);
    @(negedge clk) reset = 1'b0;
    m_cnt = 0; m_nzcv = 4'd0; exp_wen = 1'b0;
    exp_q.delete(); ex_q.delete(); mem_q.delete();
    @(posedge clk);
    #1;
    cycle();
    cycle();

    // Service resumes normally after reset
    ex_q.push_back(mk(5'd9, 16'h0F0F, 4'b0101, 1'b1));
    mem_q.push_back(mk(5'd9, 16'h9999, 4'd0, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
